regfile_wport_arbiter: RTL

Shares the single general-purpose register file write port between the in-order pipeline writeback stage and the long-latency auxiliary unit (multiply/divide, cache-miss load return). It keeps a per-register scoreboard of outstanding auxiliary writes, so decode stalls on an operand whose value is not yet written. It sits between the WB stage, the auxiliary unit and the register file, and drives the register file's `we`/`waddr`/`write_data` inputs directly.

---
 rtl/regfile_wport_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter
// Arbitrates the single register-file write port between the in-order
// pipeline writeback stage and the long-latency auxiliary unit. It also keeps
// a per-register scoreboard of outstanding auxiliary writes so that decode can
// stall on operands that have not been written yet.
//
// Build option: define RF_ARB_STARVE_GUARD_EN to enable the starvation guard.
// With the guard, an auxiliary request refused STARVE_LIMIT cycles in a row is
// forced through on the next cycle. Without it, the pipeline has strict
// priority and STARVE_LIMIT has no effect.
//
// Grants are combinational, so a request is accepted in the same cycle it is
// presented. All outputs are held at 0 while reset is low.

module regfile_wport_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    output logic        pipe_ready,
    input  logic        aux_valid,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    input  logic        sb_set,
    input  logic [4:0]  sb_set_addr,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic        busy1,
    output logic        busy2,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    logic        w_aux_force;
    logic        w_pipe_ready;
    logic        w_aux_ready;
    logic        w_pipe_grant;
    logic        w_aux_grant;
    logic [31:0] r_pending;
    logic [31:0] w_pending_nxt;

`ifdef RF_ARB_STARVE_GUARD_EN
    typedef enum logic {
        PIPE_PRI  = 1'b0,
        AUX_FORCE = 1'b1
    } arb_state_e;

    localparam logic [3:0] LP_WAIT_LAST = 4'(STARVE_LIMIT - 1);

    arb_state_e r_state;
    logic [3:0] r_wait_cnt;
    logic       w_aux_refused;

    assign w_aux_refused = aux_valid && !w_aux_ready;
    assign w_aux_force   = (r_state == AUX_FORCE);

    // Count consecutive auxiliary refusals and force a single auxiliary grant
    // once the limit is reached.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= PIPE_PRI;
            r_wait_cnt <= 4'd0;
        end else begin
            r_wait_cnt <= w_aux_refused ? (r_wait_cnt + 4'd1) : 4'd0;
            case (r_state)
                PIPE_PRI: begin
                    if (w_aux_refused && (r_wait_cnt == LP_WAIT_LAST)) begin
                        r_state <= AUX_FORCE;
                    end
                end
                AUX_FORCE: begin
                    // One forced grant, or the request went away: either way
                    // the pipeline regains priority.
                    if (w_aux_grant || !aux_valid) begin
                        r_state <= PIPE_PRI;
                    end
                end
                default: r_state <= PIPE_PRI;
            endcase
        end
    end
`else
    // Strict pipeline priority; the starvation limit is only kept as a port
    // of the parameter list so both builds share one instantiation.
    logic [3:0] w_unused_limit;
    assign w_unused_limit = 4'(STARVE_LIMIT);
    assign w_aux_force    = 1'b0;
`endif

    // The loser of the arbitration sees ready low; everything is gated off
    // while reset is asserted so the outputs read 0 immediately.
    assign w_pipe_ready = reset && (!w_aux_force || !aux_valid);
    assign w_aux_ready  = reset && (w_aux_force || !pipe_valid);
    assign w_pipe_grant = pipe_valid && w_pipe_ready;
    assign w_aux_grant  = aux_valid && w_aux_ready;

    assign pipe_ready = w_pipe_ready;
    assign aux_ready  = w_aux_ready;

    // Write-port mux: at most one grant is ever active, idle port drives 0.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (w_pipe_grant) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_addr;
            rf_wdata = pipe_data;
        end else if (w_aux_grant) begin
            rf_we    = 1'b1;
            rf_waddr = aux_addr;
            rf_wdata = aux_data;
        end
    end

    // Next scoreboard value: clear on accepted aux write, then set on issue so
    // a same-cycle set wins; register 0 never becomes pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_aux_grant) begin
            w_pending_nxt[aux_addr] = 1'b0;
        end
        if (sb_set) begin
            w_pending_nxt[sb_set_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    // NOTE: the pending bits are reset, unlike a data memory, because a stale
    // bit would stall decode on a write that will never arrive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Operand stall: pending and not being written right now (bypass covers it).
    assign busy1 = reset && (rd_addr1 != 5'd0) && r_pending[rd_addr1]
                   && !(w_aux_grant && (aux_addr == rd_addr1));
    assign busy2 = reset && (rd_addr2 != 5'd0) && r_pending[rd_addr2]
                   && !(w_aux_grant && (aux_addr == rd_addr2));

endmodule
